// File: rtl/mmul_loop_sequencer_if.sv
`default_nettype none
// ============================================================================
// mmul_loop_sequencer_if : start/index-stream bundle for mmul_loop_sequencer
// Optional abort member present only with MMUL_SEQ_ABORT_EN.  Rev 1.0
// ============================================================================
interface mmul_loop_sequencer_if #(
  parameter int unsigned IDX_W = 32,
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             busy;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] k;
  logic             first_k;
  logic             last_k;
  logic [CNT_W-1:0] beat_cnt;
  logic             done;
`ifdef MMUL_SEQ_ABORT_EN
  logic             abort;
`endif

  // master: the sequencer producing the index stream
  modport master (
`ifdef MMUL_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, idx_ready,
    output busy, idx_valid, i, j, k, first_k, last_k, beat_cnt, done
  );

  modport slave (
`ifdef MMUL_SEQ_ABORT_EN
    output abort,
`endif
    output start, idx_ready,
    input  busy, idx_valid, i, j, k, first_k, last_k, beat_cnt, done
  );
endinterface
`default_nettype wire

// File: rtl/mmul_loop_sequencer.sv
`default_nettype none
// ============================================================================
// mmul_loop_sequencer : (i,j,k) loop-index stream for C = A * B with
// start/busy, valid/ready, first_k/last_k strobes and beat count.
// Optional abort via `define MMUL_SEQ_ABORT_EN.  Rev 1.0
// ============================================================================
module mmul_loop_sequencer #(
  parameter int unsigned RA    = 1,
  parameter int unsigned CA    = 1,
  parameter int unsigned RB    = 1,
  parameter int unsigned CB    = 1,
  parameter int unsigned IDX_W = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmul_loop_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] C_I_LAST = IDX_W'(RA - 1);
  localparam logic [IDX_W-1:0] C_J_LAST = IDX_W'(CB - 1);
  localparam logic [IDX_W-1:0] C_K_LAST = IDX_W'(RB - 1);

  generate
    if (CA != RB) begin : g_dim_mismatch
      $error("mmul_loop_sequencer: CA (%0d) must equal RB (%0d)", CA, RB);
    end
    if (RA == 0 || RB == 0 || CB == 0) begin : g_dim_zero
      $error("mmul_loop_sequencer: RA, RB and CB must be at least 1");
    end
    if (IDX_W < 32) begin : g_idx_w_check
      if ((RA - 1) >= (32'd1 << IDX_W) || (RB - 1) >= (32'd1 << IDX_W) ||
          (CB - 1) >= (32'd1 << IDX_W)) begin : g_idx_w_small
        $error("mmul_loop_sequencer: IDX_W too narrow for loop bounds");
      end
    end
    if (CNT_W < 63) begin : g_cnt_w_check
      if ((64'(RA) * 64'(CB) * 64'(RB)) > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_small
        $error("mmul_loop_sequencer: CNT_W too narrow for RA*CB*RB");
      end
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_valid;
  logic w_fire;
  logic w_k_last;
  logic w_j_last;
  logic w_i_last;

  assign w_valid  = (state_q == S_RUN);
  assign w_fire   = w_valid && bus.idx_ready;
  assign w_k_last = (k_q == C_K_LAST);
  assign w_j_last = (j_q == C_J_LAST);
  assign w_i_last = (i_q == C_I_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
`ifdef MMUL_SEQ_ABORT_EN
        // Abort cancels the beat on offer, so it is not counted.
        if (bus.abort) begin
          state_d = S_IDLE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else
`endif
        if (w_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!w_k_last) begin
            k_d = k_q + IDX_W'(1);
          end else begin
            k_d = '0;
            if (!w_j_last) begin
              j_d = j_q + IDX_W'(1);
            end else begin
              j_d = '0;
              if (!w_i_last) begin
                i_d = i_q + IDX_W'(1);
              end else begin
                // Final beat: indices return to zero, never past the bounds.
                i_d     = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.idx_valid = w_valid;
  assign bus.i         = i_q;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.first_k   = w_valid && (k_q == '0);
  assign bus.last_k    = w_valid && w_k_last;
  assign bus.beat_cnt  = cnt_q;
  assign bus.done      = (state_q == S_DONE);

  a_done_not_valid : assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |-> !bus.idx_valid);

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.idx_valid && !bus.idx_ready
`ifdef MMUL_SEQ_ABORT_EN
     && !bus.abort
`endif
    ) |=> (bus.idx_valid && $stable(bus.i) && $stable(bus.j) && $stable(bus.k)));

endmodule
`default_nettype wire
